// File: rtl/imem_boot_loader_pkg.sv
// Shared encodings and widths for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned HDR_W          = 16;

    localparam logic [2:0] HDR0 = 3'd0;
    localparam logic [2:0] HDR1 = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    typedef enum logic [2:0] {
        S_HDR0 = HDR0,
        S_HDR1 = HDR1,
        S_DATA = DATA,
        S_WR   = WR,
        S_DONE = DONE,
        S_ERR  = ERR
    } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer: byte 0 lands in [7:0], byte 3 in [31:24].
module imem_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic              word_valid_c_o,
    output logic [WORD_W-1:0] word_c_o
);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;

    // The word includes the byte being accepted this cycle, so the write can issue next cycle.
    assign word_c_o       = {data_i, shreg_q[WORD_W-1:BYTE_W]};
    assign word_valid_c_o = accept_i && !clear_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    always_comb begin
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (clear_i) begin
            idx_d   = '0;
            shreg_d = '0;
        end else if (accept_i) begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = word_c_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then releases the core
// and hands the memory read port to the core's PC.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned INS_ADDRESS = 9,
    parameter int unsigned INS_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   reload,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    input  logic [INS_ADDRESS-1:0] pc,
    output logic [INS_ADDRESS-1:0] mem_ra,
    output logic                   mem_we,
    output logic [INS_ADDRESS-1:0] mem_wa,
    output logic [INS_W-1:0]       mem_wd,
    output logic                   core_rst_n,
    output logic                   boot_done,
    output logic                   load_err
);

    localparam int unsigned WIDX_W = INS_ADDRESS - 2;
    localparam int unsigned DEPTH  = 2 ** WIDX_W;

    state_e                 state_q, state_d;
    logic [HDR_W-1:0]       len_q, len_d;
    logic [WIDX_W-1:0]      widx_q, widx_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   mem_we_q, mem_we_d;
    logic [INS_ADDRESS-1:0] mem_wa_q, mem_wa_d;
    logic [INS_W-1:0]       mem_wd_q, mem_wd_d;
    logic                   boot_done_q, boot_done_d;
    logic                   load_err_q, load_err_d;
    logic                   core_rst_n_q, core_rst_n_d;

    logic              hs;
    logic              pk_accept;
    logic              pk_word_valid;
    logic [WORD_W-1:0] pk_word;

    assign hs        = rx_valid && rx_ready_q;
    assign pk_accept = hs && (state_q == S_DATA) && !reload;

    imem_word_packer u_packer (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (reload),
        .accept_i       (pk_accept),
        .data_i         (rx_data),
        .word_valid_c_o (pk_word_valid),
        .word_c_o       (pk_word)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        widx_d   = widx_q;
        mem_we_d = 1'b0;
        mem_wa_d = mem_wa_q;
        mem_wd_d = mem_wd_q;

        if (reload) begin
            state_d = S_HDR0;
            widx_d  = '0;
        end else begin
            case (state_q)
                S_HDR0: if (hs) begin
                    len_d[BYTE_W-1:0] = rx_data;
                    state_d           = S_HDR1;
                end
                S_HDR1: if (hs) begin
                    len_d = {rx_data, len_q[BYTE_W-1:0]};
                    if (len_d == '0)                   state_d = S_DONE;
                    else if (len_d > HDR_W'(DEPTH))    state_d = S_ERR;
                    else                               state_d = S_DATA;
                end
                S_DATA: if (pk_word_valid) begin
                    state_d  = S_WR;
                    mem_we_d = 1'b1;
                    mem_wa_d = {widx_q, 2'b00};
                    mem_wd_d = INS_W'(pk_word);
                end
                S_WR: begin
                    widx_d  = widx_q + WIDX_W'(1);
                    state_d = (HDR_W'(widx_q) + HDR_W'(1) == len_q) ? S_DONE : S_DATA;
                end
                S_DONE:  state_d = S_DONE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_HDR0;
            endcase
        end

        // Status outputs follow the state being entered, so they change together with it.
        rx_ready_d   = (state_d != S_WR) && (state_d != S_DONE);
        boot_done_d  = (state_d == S_DONE);
        core_rst_n_d = (state_d == S_DONE);
        load_err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HDR0;
            len_q        <= '0;
            widx_q       <= '0;
            rx_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wa_q     <= '0;
            mem_wd_q     <= '0;
            boot_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            widx_q       <= widx_d;
            rx_ready_q   <= rx_ready_d;
            mem_we_q     <= mem_we_d;
            mem_wa_q     <= mem_wa_d;
            mem_wd_q     <= mem_wd_d;
            boot_done_q  <= boot_done_d;
            load_err_q   <= load_err_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_wa     = mem_wa_q;
    assign mem_wd     = mem_wd_q;
    assign boot_done  = boot_done_q;
    assign load_err   = load_err_q;
    assign core_rst_n = core_rst_n_q;

    // The core is held in reset during the load, so the read port shadows the write address.
    assign mem_ra = boot_done_q ? pc : mem_wa_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader with a byte-queue reference model.
module tb_imem_boot_loader;

    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 128;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          reload   = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic [AW-1:0] pc       = '0;
    logic          rx_ready, mem_we, core_rst_n, boot_done, load_err;
    logic [AW-1:0] mem_ra, mem_wa;
    logic [31:0]   mem_wd;

    imem_boot_loader #(.INS_ADDRESS(AW), .INS_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reload     (reload),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .pc         (pc),
        .mem_ra     (mem_ra),
        .mem_we     (mem_we),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .core_rst_n (core_rst_n),
        .boot_done  (boot_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] wr_wa[$];
    logic [31:0]   wr_wd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference model: header byte count, accepted data bytes, words written.
    bit            m_started = 1'b0;
    int            m_hdr     = 0;
    int unsigned   m_len     = 0;
    bit            m_done    = 1'b0;
    bit            m_err     = 1'b0;
    bit            m_we      = 1'b0;
    int            m_words   = 0;
    logic [AW-1:0] m_wa_last = '0;
    logic [31:0]   m_wd      = '0;
    logic [7:0]    m_q[$];

    function automatic bit m_rdy();
        return m_started && !m_done && !m_we;
    endfunction

    always @(negedge rst_n) begin
        m_started = 1'b0; m_hdr = 0; m_len = 0; m_done = 1'b0; m_err = 1'b0;
        m_we = 1'b0; m_words = 0; m_wa_last = '0; m_wd = '0; m_q.delete();
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit hs;
            hs = rx_valid && m_rdy();
            if (reload) begin
                m_hdr = 0; m_words = 0; m_q.delete(); m_done = 1'b0; m_err = 1'b0; m_we = 1'b0;
            end else if (m_we) begin
                m_we = 1'b0;
                if (m_words == int'(m_len)) m_done = 1'b1;
            end else if (hs) begin
                if (m_hdr == 0) begin
                    m_len = 32'(rx_data);
                    m_hdr = 1;
                end else if (m_hdr == 1) begin
                    m_len = m_len | (32'(rx_data) << 8);
                    m_hdr = 2;
                    if (m_len == 0) m_done = 1'b1;
                    else if (m_len > DEPTH) m_err = 1'b1;
                end else if (!m_err) begin
                    m_q.push_back(rx_data);
                    if (m_q.size() == 4) begin
                        m_wd      = {m_q[3], m_q[2], m_q[1], m_q[0]};
                        m_wa_last = AW'(m_words * 4);
                        m_words++;
                        m_we = 1'b1;
                        m_q.delete();
                    end
                end
            end
            m_started = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("rx_ready",   32'(rx_ready),   32'(m_rdy()));
        chk("mem_we",     32'(mem_we),     32'(m_we));
        chk("boot_done",  32'(boot_done),  32'(m_done));
        chk("core_rst_n", 32'(core_rst_n), 32'(m_done));
        chk("load_err",   32'(load_err),   32'(m_err));
        chk("mem_wa",     32'(mem_wa),     32'(m_wa_last));
        chk("mem_ra",     32'(mem_ra),     32'(m_done ? pc : m_wa_last));
        if (m_we) chk("mem_wd", mem_wd, m_wd);
        if (mem_we) begin
            wr_wa.push_back(mem_wa);
            wr_wd.push_back(mem_wd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pc = AW'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int pct);
        bit taken = 1'b0;
        for (int g = 0; g < 200 && !taken; g++) begin
            if (int'($urandom_range(0, 99)) < pct) begin
                rx_valid = 1'b1;
                rx_data  = b;
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
            taken = rx_valid && rx_ready;
            step();
        end
        rx_valid = 1'b0;
        if (!taken) fail("send_byte");
    endtask

    task automatic do_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!boot_done && n < bound) begin
            step();
            n++;
        end
        if (!boot_done) fail("wait_done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] t1[8];
        logic [7:0] t4[512];
        int         nwr;
        int         len;
        t1 = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h33, 8'h70, 8'h00, 8'h00};

        // Reset values while rst_n is held low, then release between edges.
        #3;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_done",     32'(boot_done), 32'd0);
        chk("rst_core",     32'(core_rst_n), 32'd0);
        chk("rst_mem_wa",   32'(mem_wa),   32'd0);
        chk("rst_mem_wd",   mem_wd,        32'd0);
        #20 rst_n = 1'b1;
        chk("rel_rx_ready", 32'(rx_ready), 32'd0);
        step();
        chk("first_edge_rx_ready", 32'(rx_ready), 32'd1);

        // Two-word program.
        send_byte(8'h02, 100);
        send_byte(8'h00, 100);
        nwr = wr_wa.size();
        for (int i = 0; i < 8; i++) begin
            send_byte(t1[i], 100);
            if (i == 3) begin
                chk("t1_we_latency", 32'(mem_we), 32'd1);
                chk("t1_wa0", 32'(mem_wa), 32'h000);
                chk("t1_wd0", mem_wd, 32'h00100013);
            end
        end
        chk("t1_we1", 32'(mem_we), 32'd1);
        chk("t1_wa1", 32'(mem_wa), 32'h004);
        chk("t1_wd1", mem_wd, 32'h00007033);
        chk("t1_not_done_in_wr", 32'(boot_done), 32'd0);
        step();
        chk("t1_done", 32'(boot_done), 32'd1);
        chk("t1_core", 32'(core_rst_n), 32'd1);
        chk("t1_rdy",  32'(rx_ready), 32'd0);
        pc = 9'h004;
        #1;
        chk("t1_mem_ra", 32'(mem_ra), 32'h004);
        chk("t1_nwr", 32'(wr_wa.size() - nwr), 32'd2);

        // Empty program.
        do_reload();
        chk("t2_reload_done", 32'(boot_done), 32'd0);
        nwr = wr_wa.size();
        send_byte(8'h00, 100);
        send_byte(8'h00, 100);
        chk("t2_done", 32'(boot_done), 32'd1);
        chk("t2_core", 32'(core_rst_n), 32'd1);
        step();
        step();
        chk("t2_nwr", 32'(wr_wa.size() - nwr), 32'd0);

        // Oversized header.
        do_reload();
        send_byte(8'h81, 100);
        send_byte(8'h00, 100);
        chk("t3_err",  32'(load_err), 32'd1);
        chk("t3_rdy",  32'(rx_ready), 32'd1);
        chk("t3_core", 32'(core_rst_n), 32'd0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 70);
        chk("t3_err_sticky", 32'(load_err), 32'd1);
        do_reload();
        chk("t3_err_clear", 32'(load_err), 32'd0);
        chk("t3_rdy_hdr0",  32'(rx_ready), 32'd1);

        // Full-depth program with a throttled source.
        do_reload();
        nwr = wr_wa.size();
        send_byte(8'h80, 100);
        send_byte(8'h00, 100);
        for (int i = 0; i < 512; i++) begin
            t4[i] = 8'($urandom);
            send_byte(t4[i], 60);
        end
        wait_done(20);
        chk("t4_nwr", 32'(wr_wa.size() - nwr), 32'd128);
        chk("t4_last_wa", 32'(wr_wa[wr_wa.size() - 1]), 32'h1FC);
        for (int k = 0; k < 128; k++) begin
            chk("t4_wa", 32'(wr_wa[nwr + k]), 32'(k * 4));
            chk("t4_wd", wr_wd[nwr + k], {t4[4*k+3], t4[4*k+2], t4[4*k+1], t4[4*k]});
        end

        // Reload mid-word, then reload coincident with a handshake.
        do_reload();
        nwr = wr_wa.size();
        send_byte(8'h02, 100);
        send_byte(8'h00, 100);
        send_byte(8'h11, 100); send_byte(8'h22, 100); send_byte(8'h33, 100); send_byte(8'h44, 100);
        send_byte(8'h55, 100); send_byte(8'h66, 100);
        do_reload();
        step();
        chk("t5_no_partial_write", 32'(wr_wa.size() - nwr), 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        reload   = 1'b1;
        step();
        reload   = 1'b0;
        rx_valid = 1'b0;
        send_byte(8'h01, 100);
        send_byte(8'h00, 100);
        send_byte(8'hA1, 100); send_byte(8'hB2, 100); send_byte(8'hC3, 100); send_byte(8'hD4, 100);
        wait_done(5);
        chk("t5_nwr", 32'(wr_wa.size() - nwr), 32'd2);
        chk("t5_wa", 32'(wr_wa[wr_wa.size() - 1]), 32'h000);
        chk("t5_wd", wr_wd[wr_wd.size() - 1], 32'hD4C3B2A1);

        // Asynchronous reset in the middle of word 2.
        do_reload();
        send_byte(8'h04, 100);
        send_byte(8'h00, 100);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 80);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("t6_rdy",  32'(rx_ready), 32'd0);
        chk("t6_we",   32'(mem_we), 32'd0);
        chk("t6_wa",   32'(mem_wa), 32'd0);
        chk("t6_wd",   mem_wd, 32'd0);
        chk("t6_ra",   32'(mem_ra), 32'd0);
        chk("t6_core", 32'(core_rst_n), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("t6_rel_rdy", 32'(rx_ready), 32'd0);
        step();
        chk("t6_edge_rdy", 32'(rx_ready), 32'd1);
        send_byte(8'h01, 100);
        send_byte(8'h00, 100);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 50);
        wait_done(5);

        // Random short programs.
        for (int p = 0; p < 3; p++) begin
            do_reload();
            len = int'($urandom_range(1, 12));
            send_byte(8'(len), 70);
            send_byte(8'h00, 70);
            for (int i = 0; i < 4 * len; i++) send_byte(8'($urandom), 50);
            wait_done(5);
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
